// File: rtl/commit_pkg.sv
// Shared types and sizing for the in-order commit buffer.
package commit_pkg;

    localparam int COMMIT_DEPTH = 8;
    localparam int TAGW         = $clog2(COMMIT_DEPTH);
    localparam int DATA_W       = 16;
    localparam int DEST_W       = 3;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              wr;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/commit_buffer_if.sv
// Dispatch, completion, flush and register-file write signals of the commit buffer.
interface commit_buffer_if #(
    parameter int DEPTH = commit_pkg::COMMIT_DEPTH
);
    import commit_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic              alloc_valid0;
    logic              alloc_valid1;
    logic              alloc_wr0;
    logic              alloc_wr1;
    logic [DEST_W-1:0] alloc_dest0;
    logic [DEST_W-1:0] alloc_dest1;
    logic              alloc_ready;
    logic [PTR_W-1:0]  alloc_tag0;
    logic [PTR_W-1:0]  alloc_tag1;

    logic              cmpl_valid0;
    logic              cmpl_valid1;
    logic [PTR_W-1:0]  cmpl_tag0;
    logic [PTR_W-1:0]  cmpl_tag1;
    logic [DATA_W-1:0] cmpl_data0;
    logic [DATA_W-1:0] cmpl_data1;

    logic              flush;

    logic              reg_write_enable0;
    logic              reg_write_enable1;
    logic [DATA_W-1:0] data_write0;
    logic [DATA_W-1:0] data_write1;
    logic [DEST_W-1:0] data_write0_address;
    logic [DEST_W-1:0] data_write1_address;

    logic [PTR_W:0]    count;

    modport slave (
        input  alloc_valid0, alloc_valid1, alloc_wr0, alloc_wr1, alloc_dest0, alloc_dest1,
        input  cmpl_valid0, cmpl_valid1, cmpl_tag0, cmpl_tag1, cmpl_data0, cmpl_data1,
        input  flush,
        output alloc_ready, alloc_tag0, alloc_tag1,
        output reg_write_enable0, reg_write_enable1, data_write0, data_write1,
        output data_write0_address, data_write1_address,
        output count
    );

    modport master (
        output alloc_valid0, alloc_valid1, alloc_wr0, alloc_wr1, alloc_dest0, alloc_dest1,
        output cmpl_valid0, cmpl_valid1, cmpl_tag0, cmpl_tag1, cmpl_data0, cmpl_data1,
        output flush,
        input  alloc_ready, alloc_tag0, alloc_tag1,
        input  reg_write_enable0, reg_write_enable1, data_write0, data_write1,
        input  data_write0_address, data_write1_address,
        input  count
    );

endinterface

// File: rtl/commit_ptr_ctr.sv
// Modulo-DEPTH ring pointer advancing by 0, 1 or 2 per cycle; clear returns it to slot 0.
module commit_ptr_ctr #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       adv,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + PTR_W'(adv);
        end
    end

endmodule

// File: rtl/commit_buffer.sv
// Two-wide in-order commit buffer. Build with COMMIT_R0_SUPPRESS_EN to squash
// register-file writes of retiring entries whose destination is register 0.
module commit_buffer
    import commit_pkg::*;
#(
    parameter int DEPTH = COMMIT_DEPTH
) (
    input logic            clock,
    input logic            reset,
    commit_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    function automatic logic wr_en(input entry_t e);
`ifdef COMMIT_R0_SUPPRESS_EN
        return e.wr && (e.dest != '0);
`else
        return e.wr;
`endif
    endfunction

    entry_t             ents [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   head_nx1;
    logic [PTR_W-1:0]   tail_nx1;
    logic [PTR_W:0]     count;

    logic               ready;
    logic               alloc0;
    logic               alloc1;
    logic               cmpl_ok0;
    logic               cmpl_ok1;
    logic               ret0_p0;
    logic               ret1_p0;
    logic               en0_p0;
    logic               en1_p0;
    logic [1:0]         n_alloc;
    logic [1:0]         n_ret;

    logic               we0_p1;
    logic               we1_p1;
    logic [DATA_W-1:0]  d0_p1;
    logic [DATA_W-1:0]  d1_p1;
    logic [DEST_W-1:0]  a0_p1;
    logic [DEST_W-1:0]  a1_p1;

    assign head_nx1 = head + PTR_W'(1);
    assign tail_nx1 = tail + PTR_W'(1);

    assign ready  = (count <= (PTR_W+1)'(DEPTH - 2));
    assign alloc0 = bus.alloc_valid0 & ready;
    assign alloc1 = alloc0 & bus.alloc_valid1;

    // Only live, still-pending entries accept a result.
    assign cmpl_ok0 = bus.cmpl_valid0 & ents[bus.cmpl_tag0].valid & ~ents[bus.cmpl_tag0].done;
    assign cmpl_ok1 = bus.cmpl_valid1 & ents[bus.cmpl_tag1].valid & ~ents[bus.cmpl_tag1].done;

    assign ret0_p0 = ents[head].valid & ents[head].done;
    assign ret1_p0 = ret0_p0 & ents[head_nx1].valid & ents[head_nx1].done;
    assign en0_p0  = ret0_p0 & wr_en(ents[head]);
    assign en1_p0  = ret1_p0 & wr_en(ents[head_nx1]);

    assign n_alloc = {1'b0, alloc0} + {1'b0, alloc1};
    assign n_ret   = {1'b0, ret0_p0} + {1'b0, ret1_p0};

    commit_ptr_ctr #(.DEPTH(DEPTH)) u_head (
        .clock (clock),
        .reset (reset),
        .clear (bus.flush),
        .adv   (n_ret),
        .ptr   (head)
    );

    commit_ptr_ctr #(.DEPTH(DEPTH)) u_tail (
        .clock (clock),
        .reset (reset),
        .clear (bus.flush),
        .adv   (n_alloc),
        .ptr   (tail)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (bus.flush) begin
            count <= '0;
        end else begin
            count <= count + (PTR_W+1)'(n_alloc) - (PTR_W+1)'(n_ret);
        end
    end

    // Port 1 completion is applied last so it wins a same-tag collision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ents[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ents[i].valid <= 1'b0;
                ents[i].done  <= 1'b0;
            end
        end else begin
            if (ret0_p0) begin
                ents[head].valid <= 1'b0;
                ents[head].done  <= 1'b0;
            end
            if (ret1_p0) begin
                ents[head_nx1].valid <= 1'b0;
                ents[head_nx1].done  <= 1'b0;
            end
            if (cmpl_ok0) begin
                ents[bus.cmpl_tag0].done <= 1'b1;
                ents[bus.cmpl_tag0].data <= bus.cmpl_data0;
            end
            if (cmpl_ok1) begin
                ents[bus.cmpl_tag1].done <= 1'b1;
                ents[bus.cmpl_tag1].data <= bus.cmpl_data1;
            end
            if (alloc0) begin
                ents[tail].valid <= 1'b1;
                ents[tail].done  <= 1'b0;
                ents[tail].wr    <= bus.alloc_wr0;
                ents[tail].dest  <= bus.alloc_dest0;
            end
            if (alloc1) begin
                ents[tail_nx1].valid <= 1'b1;
                ents[tail_nx1].done  <= 1'b0;
                ents[tail_nx1].wr    <= bus.alloc_wr1;
                ents[tail_nx1].dest  <= bus.alloc_dest1;
            end
        end
    end

    // Retire stage boundary: register-file write ports, data held while idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            we0_p1 <= 1'b0;
            we1_p1 <= 1'b0;
            d0_p1  <= '0;
            d1_p1  <= '0;
            a0_p1  <= '0;
            a1_p1  <= '0;
        end else if (bus.flush) begin
            we0_p1 <= 1'b0;
            we1_p1 <= 1'b0;
        end else begin
            we0_p1 <= en0_p0;
            we1_p1 <= en1_p0;
            if (en0_p0) begin
                d0_p1 <= ents[head].data;
                a0_p1 <= ents[head].dest;
            end
            if (en1_p0) begin
                d1_p1 <= ents[head_nx1].data;
                a1_p1 <= ents[head_nx1].dest;
            end
        end
    end

    assign bus.alloc_ready         = ready;
    assign bus.alloc_tag0          = tail;
    assign bus.alloc_tag1          = tail_nx1;
    assign bus.count               = count;
    assign bus.reg_write_enable0   = we0_p1;
    assign bus.reg_write_enable1   = we1_p1;
    assign bus.data_write0         = d0_p1;
    assign bus.data_write1         = d1_p1;
    assign bus.data_write0_address = a0_p1;
    assign bus.data_write1_address = a1_p1;

endmodule

// File: tb/tb_commit_buffer.sv
// Bench for commit_buffer: queue-based reference model checked every cycle plus directed scenarios.
module tb_commit_buffer;
    import commit_pkg::*;

    localparam int DEPTH = COMMIT_DEPTH;
    localparam int PW    = $clog2(DEPTH);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    commit_buffer_if #(.DEPTH(DEPTH)) bus ();
    commit_buffer #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: live entries in allocation order.
    typedef struct {
        int tag;
        bit wr;
        int dest;
        bit done;
        int data;
    } ment_t;

    ment_t mq[$];
    int    mtail    = 0;
    bit    model_ok = 1'b0;
    int    e_we0 = 0, e_we1 = 0, e_d0 = 0, e_d1 = 0, e_a0 = 0, e_a1 = 0;

    bit    logging = 1'b0;
    int    rlog[$];

    function automatic bit en_of(input ment_t e);
`ifdef COMMIT_R0_SUPPRESS_EN
        return e.wr && (e.dest != 0);
`else
        return e.wr;
`endif
    endfunction

    always @(posedge clock) begin : model
        int    sz, f0, f1;
        bit    r0, r1;
        ment_t x;
        if (reset === 1'b0) begin
            mq.delete();
            mtail = 0;
            e_we0 = 0; e_we1 = 0; e_d0 = 0; e_d1 = 0; e_a0 = 0; e_a1 = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (bus.flush) begin
                mq.delete();
                mtail = 0;
                e_we0 = 0;
                e_we1 = 0;
            end else begin
                sz = mq.size();
                r0 = (sz > 0) && mq[0].done;
                r1 = r0 && (sz > 1) && mq[1].done;
                e_we0 = 0;
                e_we1 = 0;
                if (r0) begin
                    x = mq.pop_front();
                    if (en_of(x)) begin e_we0 = 1; e_d0 = x.data; e_a0 = x.dest; end
                end
                if (r1) begin
                    x = mq.pop_front();
                    if (en_of(x)) begin e_we1 = 1; e_d1 = x.data; e_a1 = x.dest; end
                end
                f0 = -1;
                f1 = -1;
                foreach (mq[i]) begin
                    if (bus.cmpl_valid0 && mq[i].tag == int'(bus.cmpl_tag0) && !mq[i].done) f0 = i;
                    if (bus.cmpl_valid1 && mq[i].tag == int'(bus.cmpl_tag1) && !mq[i].done) f1 = i;
                end
                if (f0 >= 0) begin mq[f0].done = 1; mq[f0].data = int'(bus.cmpl_data0); end
                if (f1 >= 0) begin mq[f1].done = 1; mq[f1].data = int'(bus.cmpl_data1); end
                if (bus.alloc_valid0 && (DEPTH - sz) >= 2) begin
                    x.tag = mtail; x.wr = bus.alloc_wr0; x.dest = int'(bus.alloc_dest0);
                    x.done = 0; x.data = 0;
                    mq.push_back(x);
                    mtail = (mtail + 1) % DEPTH;
                    if (bus.alloc_valid1) begin
                        x.tag = mtail; x.wr = bus.alloc_wr1; x.dest = int'(bus.alloc_dest1);
                        mq.push_back(x);
                        mtail = (mtail + 1) % DEPTH;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("count",       bus.count,               mq.size());
            check("alloc_ready", bus.alloc_ready,         (DEPTH - mq.size()) >= 2);
            check("alloc_tag0",  bus.alloc_tag0,          mtail);
            check("alloc_tag1",  bus.alloc_tag1,          (mtail + 1) % DEPTH);
            check("we0",         bus.reg_write_enable0,   e_we0);
            check("we1",         bus.reg_write_enable1,   e_we1);
            check("data0",       bus.data_write0,         e_d0);
            check("data1",       bus.data_write1,         e_d1);
            check("addr0",       bus.data_write0_address, e_a0);
            check("addr1",       bus.data_write1_address, e_a1);
            if (logging && bus.reg_write_enable0 === 1'b1) rlog.push_back(int'(bus.data_write0));
            if (logging && bus.reg_write_enable1 === 1'b1) rlog.push_back(int'(bus.data_write1));
        end
    end

    task automatic drive_idle();
        bus.alloc_valid0 = 0; bus.alloc_valid1 = 0;
        bus.alloc_wr0 = 0;    bus.alloc_wr1 = 0;
        bus.alloc_dest0 = '0; bus.alloc_dest1 = '0;
        bus.cmpl_valid0 = 0;  bus.cmpl_valid1 = 0;
        bus.cmpl_tag0 = '0;   bus.cmpl_tag1 = '0;
        bus.cmpl_data0 = '0;  bus.cmpl_data1 = '0;
        bus.flush = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic alloc2(input logic [2:0] d0, input logic [2:0] d1);
        bus.alloc_valid0 = 1; bus.alloc_wr0 = 1; bus.alloc_dest0 = d0;
        bus.alloc_valid1 = 1; bus.alloc_wr1 = 1; bus.alloc_dest1 = d1;
        cyc();
        drive_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k, na, t0, t1, j, budget;
        int ptag[$];
        int pdat[$];

        drive_idle();
        reset = 1'b0;
        repeat (2) cyc();
        check("rst_count", bus.count, 0);
        check("rst_we0", bus.reg_write_enable0, 0);
        check("rst_we1", bus.reg_write_enable1, 0);
        check("rst_data0", bus.data_write0, 0);
        check("rst_addr1", bus.data_write1_address, 0);
        reset = 1'b1;
        check("rel_ready", bus.alloc_ready, 1);
        check("rel_tag0", bus.alloc_tag0, 0);
        check("rel_tag1", bus.alloc_tag1, 1);

        // Out-of-order completion, paired retirement.
        alloc2(3'd3, 3'd5);
        check("t1_count", bus.count, 2);
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(1); bus.cmpl_data0 = 16'h00BB;
        cyc(); drive_idle();
        bus.cmpl_valid1 = 1; bus.cmpl_tag1 = PW'(0); bus.cmpl_data1 = 16'h00AA;
        cyc(); drive_idle();
        check("t1_not_yet", bus.reg_write_enable0, 0);
        cyc();
        check("t1_we0", bus.reg_write_enable0, 1);
        check("t1_addr0", bus.data_write0_address, 3);
        check("t1_data0", bus.data_write0, 16'h00AA);
        check("t1_we1", bus.reg_write_enable1, 1);
        check("t1_addr1", bus.data_write1_address, 5);
        check("t1_data1", bus.data_write1, 16'h00BB);
        check("t1_count0", bus.count, 0);

        // Fill to DEPTH-1 entries; requests while not ready are dropped.
        check("t2_tag0", bus.alloc_tag0, 2);
        repeat (3) alloc2(3'd1, 3'd4);
        bus.alloc_valid0 = 1; bus.alloc_wr0 = 1; bus.alloc_dest0 = 3'd7;
        cyc(); drive_idle();
        check("t2_count7", bus.count, 7);
        check("t2_not_ready", bus.alloc_ready, 0);
        bus.alloc_valid0 = 1; bus.alloc_valid1 = 1; bus.alloc_wr0 = 1; bus.alloc_wr1 = 1;
        repeat (2) cyc();
        drive_idle();
        check("t2_hold_count", bus.count, 7);
        check("t2_hold_tag", bus.alloc_tag0, 1);
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(2); bus.cmpl_data0 = 16'h0777;
        cyc(); drive_idle();
        cyc();
        check("t2_count6", bus.count, 6);
        check("t2_ready", bus.alloc_ready, 1);
        check("t2_data0", bus.data_write0, 16'h0777);
        bus.flush = 1;
        cyc(); drive_idle();
        check("t2_flush_count", bus.count, 0);

        // Same destination, younger value on port 1.
        alloc2(3'd2, 3'd2);
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(0); bus.cmpl_data0 = 16'h1111;
        bus.cmpl_valid1 = 1; bus.cmpl_tag1 = PW'(1); bus.cmpl_data1 = 16'h2222;
        cyc(); drive_idle();
        cyc();
        check("t3_we0", bus.reg_write_enable0, 1);
        check("t3_we1", bus.reg_write_enable1, 1);
        check("t3_addr0", bus.data_write0_address, 2);
        check("t3_addr1", bus.data_write1_address, 2);
        check("t3_data1", bus.data_write1, 16'h2222);

        // Same-tag completion collision, then a late completion to a done entry.
        bus.alloc_valid0 = 1; bus.alloc_wr0 = 1; bus.alloc_dest0 = 3'd6;
        cyc(); drive_idle();
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(2); bus.cmpl_data0 = 16'hDEAD;
        bus.cmpl_valid1 = 1; bus.cmpl_tag1 = PW'(2); bus.cmpl_data1 = 16'hBEEF;
        cyc(); drive_idle();
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(2); bus.cmpl_data0 = 16'h9999;
        cyc(); drive_idle();
        check("t4_we0", bus.reg_write_enable0, 1);
        check("t4_data0", bus.data_write0, 16'hBEEF);
        check("t4_we1", bus.reg_write_enable1, 0);
        check("t4_hold1", bus.data_write1, 16'h2222);

        // Flush with pending work and a same-cycle completion and allocation.
        alloc2(3'd1, 3'd2);
        alloc2(3'd3, 3'd4);
        check("t5_count4", bus.count, 4);
        bus.flush = 1;
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(3); bus.cmpl_data0 = 16'h3333;
        bus.alloc_valid0 = 1; bus.alloc_wr0 = 1;
        cyc(); drive_idle();
        check("t5_count0", bus.count, 0);
        check("t5_tag0", bus.alloc_tag0, 0);
        check("t5_we0", bus.reg_write_enable0, 0);
        check("t5_we1", bus.reg_write_enable1, 0);
        cyc();
        check("t5_quiet", bus.reg_write_enable0, 0);
        check("t5_hold0", bus.data_write0, 16'hBEEF);

        // Register 0 destination.
        bus.alloc_valid0 = 1; bus.alloc_wr0 = 1; bus.alloc_dest0 = 3'd0;
        cyc(); drive_idle();
        bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(0); bus.cmpl_data0 = 16'h0D0D;
        cyc(); drive_idle();
        cyc();
        check("t6_count", bus.count, 0);
`ifdef COMMIT_R0_SUPPRESS_EN
        check("t6_we0_r0", bus.reg_write_enable0, 0);
        check("t6_data_hold", bus.data_write0, 16'hBEEF);
`else
        check("t6_we0_r0", bus.reg_write_enable0, 1);
        check("t6_data_r0", bus.data_write0, 16'h0D0D);
`endif

        // 20 allocations across the wrap, completed in random order.
        rlog.delete();
        logging = 1'b1;
        k = 0;
        budget = 0;
        while ((k < 20 || ptag.size() > 0) && budget < 500) begin
            na = 0;
            drive_idle();
            if (k < 20 && bus.alloc_ready === 1'b1 && $urandom_range(0, 2) != 0) begin
                bus.alloc_valid0 = 1; bus.alloc_wr0 = 1;
                bus.alloc_dest0 = (k % 2 == 0) ? 3'd1 : 3'd2;
                t0 = int'(bus.alloc_tag0);
                na = 1;
                if (k + 1 < 20 && $urandom_range(0, 1) == 1) begin
                    bus.alloc_valid1 = 1; bus.alloc_wr1 = 1;
                    bus.alloc_dest1 = ((k + 1) % 2 == 0) ? 3'd1 : 3'd2;
                    t1 = int'(bus.alloc_tag1);
                    na = 2;
                end
            end
            if (ptag.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, ptag.size() - 1);
                bus.cmpl_valid0 = 1; bus.cmpl_tag0 = PW'(ptag[j]); bus.cmpl_data0 = 16'(pdat[j]);
                ptag.delete(j); pdat.delete(j);
            end
            if (ptag.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, ptag.size() - 1);
                bus.cmpl_valid1 = 1; bus.cmpl_tag1 = PW'(ptag[j]); bus.cmpl_data1 = 16'(pdat[j]);
                ptag.delete(j); pdat.delete(j);
            end
            cyc();
            if (na >= 1) begin ptag.push_back(t0); pdat.push_back(16'h5000 + k); k++; end
            if (na == 2) begin ptag.push_back(t1); pdat.push_back(16'h5000 + k); k++; end
            budget++;
        end
        drive_idle();
        repeat (4) cyc();
        logging = 1'b0;
        check("t7_budget", budget < 500, 1);
        check("t7_retired", rlog.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check("t7_order", (i < rlog.size()) ? rlog[i] : 32'hFFFF_FFFF, 16'h5000 + i);
        end

        // Unconstrained traffic including stray completions, flushes and resets.
        for (int n = 0; n < 300; n++) begin
            bus.alloc_valid0 = 1'($urandom_range(0, 1));
            bus.alloc_valid1 = 1'($urandom_range(0, 1));
            bus.alloc_wr0    = 1'($urandom_range(0, 1));
            bus.alloc_wr1    = 1'($urandom_range(0, 1));
            bus.alloc_dest0  = 3'($urandom_range(0, 7));
            bus.alloc_dest1  = 3'($urandom_range(0, 7));
            bus.cmpl_valid0  = 1'($urandom_range(0, 1));
            bus.cmpl_valid1  = 1'($urandom_range(0, 1));
            bus.cmpl_tag0    = PW'($urandom_range(0, DEPTH - 1));
            bus.cmpl_tag1    = PW'($urandom_range(0, DEPTH - 1));
            bus.cmpl_data0   = 16'($urandom);
            bus.cmpl_data1   = 16'($urandom);
            bus.flush        = ($urandom_range(0, 39) == 0);
            reset            = ($urandom_range(0, 99) != 0);
            cyc();
        end
        reset = 1'b1;
        drive_idle();
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
